calc_bcd_formatter: RTL and testbench

CALC_BCD_FORMATTER -- requirements
Module: calc_bcd_formatter

---
 rtl/calc_pkg.sv | 11 +
 rtl/calc_bcd_add3.sv | 7 +
 rtl/calc_bcd_formatter.sv | 65 ++++++
 tb/tb_calc_bcd_formatter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared state encoding, error codes and sizing for the BCD formatter
package calc_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
  localparam logic [1:0] ERR_OK = 2'b00;
  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_DIV0 = 2'b10;
  localparam logic [1:0] ERR_INV = 2'b11;
  localparam int NUM_DIGITS = 5;
  localparam int NUM_ITER = 16;
  localparam int CNT_W = 5;
endpackage

// File: rtl/calc_bcd_add3.sv
// calc_bcd_add3: double-dabble digit corrector, adds 3 to any digit of 5 or more
module calc_bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/calc_bcd_formatter.sv
// calc_bcd_formatter: converts a calculator result into five BCD digits, sign and error code
module calc_bcd_formatter
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] result,
  input  logic        signed_operation,
  input  logic        valid,
  input  logic        overflow,
  input  logic        divide_by_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] bcd_digits,
  output logic        negative,
  output logic [1:0]  err_code
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [15:0] mag, mag_in;
  logic [19:0] bcd, adj;
  logic [1:0] err_nx;
  logic accept, neg_in, last;
  assign err_nx = divide_by_zero ? ERR_DIV0 : !valid ? ERR_INV : overflow ? ERR_OVF : ERR_OK;
  assign neg_in = signed_operation && result[15];
  assign mag_in = neg_in ? -result : result;
  assign accept = in_valid && in_ready;
  assign last = cnt == CNT_W'(NUM_ITER - 1);
  assign bcd_digits = bcd;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
    calc_bcd_add3 u_add3 (.d(bcd[4*i +: 4]), .q(adj[4*i +: 4]));
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (accept ? (err_nx[1] ? DONE : CONVERT) : IDLE)
             : state == CONVERT ? (last ? DONE : CONVERT)
             : (out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      mag <= '0;
      bcd <= '0;
      negative <= 1'b0;
      err_code <= ERR_OK;
    end else if (accept) begin
      cnt <= '0;
      mag <= err_nx[1] ? 16'd0 : mag_in;
      bcd <= '0;
      negative <= !err_nx[1] && neg_in;
      err_code <= err_nx;
    end else if (state == CONVERT) begin
      cnt <= last ? cnt : cnt + CNT_W'(1);
      {bcd, mag} <= {adj[18:0], mag, 1'b0};
    end
endmodule

// File: tb/tb_calc_bcd_formatter.sv
// tb_calc_bcd_formatter: directed self-checking bench for calc_bcd_formatter
module tb_calc_bcd_formatter;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, signed_operation, valid, overflow, divide_by_zero;
  logic out_valid, out_ready, negative;
  logic [15:0] result;
  logic [19:0] bcd_digits;
  logic [1:0] err_code;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  calc_bcd_formatter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .signed_operation(signed_operation), .valid(valid),
    .overflow(overflow), .divide_by_zero(divide_by_zero), .out_valid(out_valid),
    .out_ready(out_ready), .bcd_digits(bcd_digits), .negative(negative), .err_code(err_code)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start(input string tag, input logic [15:0] r, input logic s, input logic v,
                       input logic o, input logic dz, input int exp_cyc,
                       input logic [19:0] eb, input logic en, input logic [1:0] ee);
    int cyc;
    @(negedge clk);
    result = r; signed_operation = s; valid = v; overflow = o; divide_by_zero = dz;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; result = ~r; signed_operation = ~s; valid = 1'b1; overflow = 1'b0; divide_by_zero = 1'b0;
    @(negedge clk);
    cyc = 1;
    chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_digits"}, 32'(bcd_digits), 32'(eb));
    chk({tag, "_negative"}, 32'(negative), 32'(en));
    chk({tag, "_err"}, 32'(err_code), 32'(ee));
  endtask
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_drain_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_drain_in_ready"}, 32'(in_ready), 32'd1);
  endtask
  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; result = 16'h0;
    signed_operation = 1'b0; valid = 1'b1; overflow = 1'b0; divide_by_zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", {9'd0, bcd_digits, negative, err_code}, 32'd0);
    start("u8", 16'h0008, 1'b0, 1'b1, 1'b0, 1'b0, 17, 20'h00008, 1'b0, 2'b00);
    drain("u8");
    start("sfffd", 16'hFFFD, 1'b1, 1'b1, 1'b0, 1'b0, 17, 20'h00003, 1'b1, 2'b00);
    drain("sfffd");
    start("uffff", 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 17, 20'h65535, 1'b0, 2'b00);
    drain("uffff");
    start("s8000", 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 17, 20'h32768, 1'b1, 2'b00);
    drain("s8000");
    start("zero", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 17, 20'h00000, 1'b0, 2'b00);
    drain("zero");
    start("div0", 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 1, 20'h00000, 1'b0, 2'b10);
    drain("div0");
    start("inv", 16'h9234, 1'b1, 1'b0, 1'b0, 1'b0, 1, 20'h00000, 1'b0, 2'b11);
    drain("inv");
    start("ovf", 16'h00FF, 1'b0, 1'b1, 1'b1, 1'b0, 17, 20'h00255, 1'b0, 2'b01);
    drain("ovf");
    start("stall", 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 17, 20'h00001, 1'b1, 2'b00);
    in_valid = 1'b1;
    result = 16'h4321;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", {8'd0, out_valid, in_ready, bcd_digits, negative, err_code},
          {8'd0, 1'b1, 1'b0, 20'h00001, 1'b1, 2'b00});
    end
    in_valid = 1'b0;
    drain("stall");
    start("after_stall", 16'd12345, 1'b0, 1'b1, 1'b0, 1'b0, 17, 20'h12345, 1'b0, 2'b00);
    drain("after_stall");
    @(negedge clk);
    result = 16'h8001; signed_operation = 1'b1; valid = 1'b1; overflow = 1'b1; divide_by_zero = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_outputs", {9'd0, bcd_digits, negative, err_code}, 32'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_stale", 32'(seen), 32'd0);
    start("post_rst", 16'd9, 1'b0, 1'b1, 1'b0, 1'b0, 17, 20'h00009, 1'b0, 2'b00);
    drain("post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
